// File: rtl/xfer_addr_gen.sv
// Transfer address generator: splits a byte range into naturally aligned
// 1/2/4-byte beats, handshaken with valid/ready, with abort and done pulse.
module xfer_addr_gen #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  length,
    input  logic [1:0]        max_size,
    input  logic              abort,
    input  logic              ready,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [1:0]        size,
    output logic [CNT_W-1:0]  remaining,
    output logic [CNT_W-1:0]  beat_count,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [1:0]        max_q;
    logic [CNT_W-1:0]  size_bytes;
    logic [ADDR_W-1:0] addr_step;
    logic              accept;

    // Pick the widest beat allowed by the stored limit, bytes left and alignment.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        size = 2'd0;
        if (max_q != 2'd0 && 32'(remaining) >= 32'd2 && !addr[0])
            size = 2'd1;
        if (max_q[1] && 32'(remaining) >= 32'd4 && addr[1:0] == 2'b00)
            size = 2'd2;
    end

    assign size_bytes = CNT_W'(1) << size;
    assign addr_step  = ADDR_W'(1) << size;
    assign valid      = (state == S_RUN);
    assign accept     = valid && ready && !abort;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:
                if (start)
                    state_nxt = (length == '0) ? S_DONE : S_RUN;
            S_RUN:
                if (abort)
                    state_nxt = S_IDLE;
                else if (accept && remaining == size_bytes)
                    state_nxt = S_DONE;
            S_DONE:
                state_nxt = S_IDLE;
            default:
                state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            addr       <= '0;
            remaining  <= '0;
            beat_count <= '0;
            max_q      <= 2'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == S_RUN);
            done  <= (state_nxt == S_DONE);
            if (state == S_IDLE && start) begin
                addr       <= base_addr;
                remaining  <= length;
                beat_count <= '0;
                max_q      <= max_size;
            end else if (accept) begin
                addr      <= addr + addr_step;
                remaining <= remaining - size_bytes;
                if (beat_count != '1)
                    beat_count <= beat_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_xfer_addr_gen.sv
// Self-checking bench for xfer_addr_gen: vector table, hand-written corner
// sequences and randomized transfers against a beat-list reference model.
module tb_xfer_addr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start, abort, ready;
    logic [31:0] base_addr;
    logic [15:0] length;
    logic [1:0]  max_size;
    logic        valid, busy, done;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [15:0] remaining, beat_count;

    logic        start8, abort8, ready8;
    logic [7:0]  base8;
    logic [7:0]  len8;
    logic [1:0]  msz8;
    logic        valid8, busy8, done8;
    logic [7:0]  addr8;
    logic [1:0]  size8;
    logic [7:0]  rem8, bc8;

    xfer_addr_gen dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .max_size(max_size), .abort(abort), .ready(ready), .valid(valid), .addr(addr),
        .size(size), .remaining(remaining), .beat_count(beat_count), .busy(busy), .done(done)
    );

    xfer_addr_gen #(.ADDR_W(8), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .base_addr(base8), .length(len8),
        .max_size(msz8), .abort(abort8), .ready(ready8), .valid(valid8), .addr(addr8),
        .size(size8), .remaining(rem8), .beat_count(bc8), .busy(busy8), .done(done8)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: list of beats a transfer must produce.
    logic [31:0] m_addr[$];
    logic [1:0]  m_size[$];
    logic [15:0] m_rem[$];
    logic [31:0] m_end;

    function automatic void build_model(input logic [31:0] b, input logic [15:0] l,
                                        input logic [1:0] m);
        logic [31:0] a;
        int r, s, maxb;
        m_addr.delete(); m_size.delete(); m_rem.delete();
        a    = b;
        r    = int'(l);
        maxb = (m == 2'd0) ? 1 : (m == 2'd1) ? 2 : 4;
        while (r > 0) begin
            s = 4;
            while (s > maxb || s > r || (a % 32'(s)) != 0) s = s / 2;
            m_addr.push_back(a);
            m_size.push_back((s == 4) ? 2'd2 : (s == 2) ? 2'd1 : 2'd0);
            m_rem.push_back(16'(r));
            a = a + 32'(s);
            r = r - s;
        end
        m_end = a;
    endfunction

    // Entered and left just after a falling edge.
    task automatic run_xfer(input logic [31:0] b, input logic [15:0] l, input logic [1:0] m,
                            input int rdy_pct, input bit noise);
        int n, idx, cyc;
        build_model(b, l, m);
        n = m_addr.size();
        start = 1'b1; base_addr = b; length = l; max_size = m; ready = 1'b0; abort = 1'b0;
        @(negedge clk);
        start = 1'b0;
        if (n == 0) begin
            check("zero_len_done", 64'(done), 64'd1);
            check("zero_len_valid", 64'(valid), 64'd0);
            check("zero_len_beats", 64'(beat_count), 64'd0);
            @(negedge clk);
            check("zero_len_pulse", 64'({done, valid}), 64'd0);
            return;
        end
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 2000) begin
            check("beat_valid_busy", 64'({valid, busy, done}), 64'b110);
            check("beat_addr", 64'(addr), 64'(m_addr[idx]));
            check("beat_size", 64'(size), 64'(m_size[idx]));
            check("beat_rem", 64'(remaining), 64'(m_rem[idx]));
            ready = ($urandom_range(99) < rdy_pct);
            if (noise) begin
                start     = 1'($urandom_range(1));
                base_addr = $urandom;
                length    = 16'($urandom);
            end
            @(negedge clk);
            if (ready) idx++;
            cyc++;
        end
        start = 1'b0;
        ready = 1'b0;
        if (idx < n) check("xfer_timeout", 64'(idx), 64'(n));
        check("end_done_state", 64'({done, valid, busy}), 64'b100);
        check("end_rem", 64'(remaining), 64'd0);
        check("end_beats", 64'(beat_count), 64'(n));
        check("end_addr", 64'(addr), 64'(m_end));
        @(negedge clk);
        check("idle_flags", 64'({done, valid, busy}), 64'b000);
        check("idle_addr_hold", 64'(addr), 64'(m_end));
    endtask

    typedef struct {
        logic [31:0] base;
        logic [15:0] len;
        logic [1:0]  msz;
        int          exp_beats;
        logic [31:0] exp_end;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{32'h100, 16'd8, 2'd2, 2, 32'h108};
        vecs[1] = '{32'h101, 16'd7, 2'd2, 3, 32'h108};
        vecs[2] = '{32'h200, 16'd6, 2'd1, 3, 32'h206};
        vecs[3] = '{32'h200, 16'd0, 2'd2, 0, 32'h200};
        vecs[4] = '{32'h003, 16'd5, 2'd3, 2, 32'h008};
        vecs[5] = '{32'h002, 16'd3, 2'd0, 3, 32'h005};
        vecs[6] = '{32'h006, 16'd9, 2'd2, 4, 32'h00F};

        rst = 1'b1;
        start = 1'b0; abort = 1'b0; ready = 1'b0; base_addr = '0; length = '0; max_size = '0;
        start8 = 1'b0; abort8 = 1'b0; ready8 = 1'b0; base8 = '0; len8 = '0; msz8 = '0;
        #22;
        check("rst_outputs", 64'({valid, busy, done, size, addr, remaining, beat_count}), 64'd0);
        check("rst_outputs8", 64'({valid8, busy8, done8, size8, addr8, rem8, bc8}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // First transfer starts on the very first edge after reset release.
        foreach (vecs[i]) begin
            run_xfer(vecs[i].base, vecs[i].len, vecs[i].msz, 100, 1'b0);
            check("vec_beats", 64'(beat_count), 64'(vecs[i].exp_beats));
            check("vec_end_addr", 64'(addr), 64'(vecs[i].exp_end));
        end

        // Stall for five cycles, accept one beat, then abort against ready.
        start = 1'b1; base_addr = 32'h100; length = 16'd8; max_size = 2'd2;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_hold", 64'({valid, size, addr, remaining}), {1'b1, 2'd2, 32'h100, 16'd8});
            @(negedge clk);
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("stall_accept", 64'({addr, remaining, beat_count}), {32'h104, 16'd4, 16'd1});
        abort = 1'b1; ready = 1'b1;
        @(negedge clk);
        abort = 1'b0; ready = 1'b0;
        check("abort_flags", 64'({valid, busy, done}), 64'b000);
        check("abort_hold", 64'({addr, remaining, beat_count}), {32'h104, 16'd4, 16'd1});
        @(negedge clk);
        check("abort_no_done", 64'({valid, busy, done}), 64'b000);

        // Abort while idle must not block a start.
        abort = 1'b1; start = 1'b1; base_addr = 32'h0; length = 16'd4; max_size = 2'd2;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("idle_abort_run", 64'({valid, busy}), 64'b11);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("idle_abort_done", 64'({done, beat_count}), {1'b1, 16'd1});
        @(negedge clk);

        // Narrow address wraps silently.
        start8 = 1'b1; base8 = 8'hFC; len8 = 8'd8; msz8 = 2'd2;
        @(negedge clk);
        start8 = 1'b0;
        check("wrap_beat0", 64'({valid8, addr8, size8, rem8}), {1'b1, 8'hFC, 2'd2, 8'd8});
        ready8 = 1'b1;
        @(negedge clk);
        check("wrap_beat1", 64'({valid8, addr8, size8, rem8}), {1'b1, 8'h00, 2'd2, 8'd4});
        @(negedge clk);
        ready8 = 1'b0;
        check("wrap_done", 64'({done8, bc8, addr8, rem8}), {1'b1, 8'd2, 8'h04, 8'd0});
        @(negedge clk);

        // Reset in mid-transfer clears everything at once.
        start8 = 1'b1; base8 = 8'h10; len8 = 8'd8; msz8 = 2'd2;
        @(negedge clk);
        start8 = 1'b0; ready8 = 1'b1;
        @(negedge clk);
        ready8 = 1'b0;
        check("pre_rst_beat", 64'({addr8, bc8}), {8'h14, 8'd1});
        #2 rst = 1'b1;
        #1;
        check("async_rst8", 64'({valid8, busy8, done8, size8, addr8, rem8, bc8}), 64'd0);
        @(negedge clk);
        check("rst_no_done", 64'({done8, valid8}), 64'd0);
        rst = 1'b0;
        start = 1'b1; base_addr = 32'h40; length = 16'd4; max_size = 2'd2;
        @(negedge clk);
        start = 1'b0;
        check("post_rst_start", 64'({valid, addr}), {1'b1, 32'h40});
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("post_rst_done", 64'(done), 64'd1);
        @(negedge clk);

        // Randomized transfers with stalls and start/base noise while running.
        for (int t = 0; t < 25; t++) begin
            run_xfer($urandom, 16'($urandom_range(40)), 2'($urandom_range(3)), 60, 1'b1);
            repeat ($urandom_range(2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
